// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache in front of a
// 128-bit block memory. Word loads/stores from the CPU and block
// READ/WRITE/BUSYWAIT handshake to memory.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache #(
  parameter int unsigned NUM_LINES = 8
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         READ,
  input  logic         WRITE,
  input  logic [31:0]  ADDRESS,
  input  logic [31:0]  WRITEDATA,
  output logic [31:0]  READDATA,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  localparam int unsigned INDEX_BITS = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS   = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t state, next_state;

  logic [127:0]          data_array [NUM_LINES];
  logic [TAG_BITS-1:0]   tag_array  [NUM_LINES];
  logic [NUM_LINES-1:0]  valid;
  logic [NUM_LINES-1:0]  dirty;
  logic [127:0]          fetch_buf;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   addr_tag;
  logic [1:0]            word;
  logic                  request;
  logic                  hit;
  logic                  write_hit;
  logic                  unused_addr_lsb;

  // Address decode and combinational hit check
  assign index           = ADDRESS[3+INDEX_BITS:4];
  assign addr_tag        = ADDRESS[31:4+INDEX_BITS];
  assign word            = ADDRESS[3:2];
  assign request         = READ ^ WRITE;
  assign hit             = request && valid[index] && (tag_array[index] == addr_tag);
  assign write_hit       = (state == IDLE) && WRITE && !READ && hit;
  assign unused_addr_lsb = ^ADDRESS[1:0];

  // State register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (request && !hit)
                   next_state = (valid[index] && dirty[index]) ? WRITEBACK : FETCH;
      WRITEBACK: if (!MEM_BUSYWAIT) next_state = FETCH;
      FETCH:     if (!MEM_BUSYWAIT) next_state = UPDATE;
      UPDATE:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Outputs decoded from state; requests drop as soon as state leaves WRITEBACK/FETCH
  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    READDATA      = '0;
    BUSYWAIT      = (state != IDLE) || (request && !hit);
    case (state)
      IDLE: begin
        if (READ && !WRITE && hit)
          READDATA = data_array[index][{word, 5'b0} +: 32];
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_array[index], index};
        MEM_WRITEDATA = data_array[index];
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[31:4];
      end
      default: ;
    endcase
  end

  // Fetched block is held here until UPDATE installs it
  always_ff @(posedge CLOCK) begin
    if (state == FETCH && !MEM_BUSYWAIT) fetch_buf <= MEM_READDATA;
  end

  // Data and tag arrays: block install on UPDATE, word store on write hit
  always_ff @(posedge CLOCK) begin
    if (state == UPDATE) begin
      data_array[index] <= fetch_buf;
      tag_array[index]  <= addr_tag;
    end else if (write_hit) begin
      data_array[index][{word, 5'b0} +: 32] <= WRITEDATA;
    end
  end

  // Valid/dirty bits; reset invalidates every line, including one being installed
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == UPDATE) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (write_hit) begin
      dirty[index] <= 1'b1;
    end
  end

`ifdef DCACHE_STATS_EN
  logic after_update;

  // Saturating hit/miss counters; the hit that completes a miss is not counted
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      after_update <= 1'b0;
      HIT_COUNT    <= '0;
      MISS_COUNT   <= '0;
    end else begin
      after_update <= (state == UPDATE);
      if (state == IDLE && hit && !after_update && HIT_COUNT != 32'hFFFF_FFFF)
        HIT_COUNT <= HIT_COUNT + 32'd1;
      if (state == IDLE && next_state != IDLE && MISS_COUNT != 32'hFFFF_FFFF)
        MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: self-checking bench for dcache (NUM_LINES=8) with a 5-cycle
// block memory. Reference is a flat word memory plus per-index residency.
module tb_dcache;

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic         READ, WRITE;
  logic [31:0]  ADDRESS, WRITEDATA;
  logic [31:0]  READDATA;
  logic         BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA, MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

  int checks = 0;
  int failures = 0;

  dcache #(.NUM_LINES(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  // Initial memory contents (block 4 fixed by the directed scenarios)
  function automatic logic [31:0] init_word(int b, int w);
    if (b == 4) return 32'h1111_1111 * 32'(w + 1);
    return 32'hB000_0000 | 32'(b << 8) | 32'(w);
  endfunction

  // Block memory: 64 blocks, 5 cycles of busy per request
  logic [127:0] mem [64];
  int unsigned  mem_cnt;
  wire          mem_req = MEM_READ | MEM_WRITE;
  assign MEM_BUSYWAIT = mem_req && (mem_cnt != 4);
  assign MEM_READDATA = mem[MEM_ADDRESS[5:0]];

  initial begin
    mem_cnt = 0;
    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 4; w++) mem[b][32*w +: 32] = init_word(b, w);
    forever begin
      @(posedge CLOCK);
      if (mem_req) begin
        if (mem_cnt == 4) begin
          if (MEM_WRITE) mem[MEM_ADDRESS[5:0]] <= MEM_WRITEDATA;
          mem_cnt <= 0;
        end else mem_cnt <= mem_cnt + 1;
      end else mem_cnt <= 0;
    end
  end

  // Reference: what each word should read as, and which block each index holds
  logic [31:0] ref_mem [256];
  bit          r_valid [8];
  bit          r_dirty [8];
  int unsigned r_tag   [8];
  int unsigned m_hits, m_misses;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      r_valid[i] = 0;
      r_dirty[i] = 0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  // One CPU access, started at posedge+1, returning at posedge+1 after completion
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
    int unsigned  idx     = int'(addr[6:4]);
    int unsigned  atag    = addr >> 7;
    bit           req     = rd ^ wr;
    bit           exp_hit = req && r_valid[idx] && (r_tag[idx] == atag);
    bit           exp_wb  = req && !exp_hit && r_valid[idx] && r_dirty[idx];
    int           exp_busy = (!req || exp_hit) ? 0 : (exp_wb ? 12 : 7);
    int unsigned  vb      = r_tag[idx] * 8 + idx;
    logic [127:0] exp_wbd;
    logic [27:0]  wb_addr, rd_addr;
    logic [127:0] wb_data;
    bit           wb_seen = 0, rd_seen = 0, both = 0;
    int           busy = 0;
    for (int w = 0; w < 4; w++) exp_wbd[32*w +: 32] = ref_mem[(vb * 4 + w) % 256];
    wb_addr = '0; rd_addr = '0; wb_data = '0;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
    forever begin
      @(negedge CLOCK);
      if (MEM_READ && MEM_WRITE) both = 1;
      if (MEM_WRITE && !wb_seen) begin wb_seen = 1; wb_addr = MEM_ADDRESS; wb_data = MEM_WRITEDATA; end
      if (MEM_READ && !rd_seen)  begin rd_seen = 1; rd_addr = MEM_ADDRESS; end
      if (!BUSYWAIT) break;
      busy++;
      if (busy > 60) begin
        chk({tag, "_timeout"}, 128'(busy), 128'(exp_busy));
        break;
      end
    end
    chk({tag, "_stall"}, 128'(busy), 128'(exp_busy));
    chk({tag, "_wb"}, 128'(wb_seen), 128'(exp_wb));
    chk({tag, "_fetch"}, 128'(rd_seen), 128'(req && !exp_hit));
    chk({tag, "_excl"}, 128'(both), 128'(0));
    if (exp_wb) begin
      chk({tag, "_wbaddr"}, 128'(wb_addr), 128'(vb));
      chk({tag, "_wbdata"}, wb_data, exp_wbd);
    end
    if (req && !exp_hit) chk({tag, "_faddr"}, 128'(rd_addr), 128'(addr[31:4]));
    if (rd && !wr) chk({tag, "_rdata"}, 128'(READDATA), 128'(ref_mem[addr[9:2]]));
    else           chk({tag, "_rzero"}, 128'(READDATA), 128'(0));
    @(posedge CLOCK);
    #1;
    READ = 0; WRITE = 0;
    if (req) begin
      if (exp_hit) m_hits++; else m_misses++;
      r_dirty[idx] = (exp_hit ? r_dirty[idx] : 1'b0) | wr;
      r_valid[idx] = 1;
      r_tag[idx]   = atag;
      if (wr) ref_mem[addr[9:2]] = wdata;
    end
  endtask

  initial begin
    RESET = 1; READ = 0; WRITE = 0; ADDRESS = '0; WRITEDATA = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i / 4, i % 4);
    model_reset();
    @(negedge CLOCK);
    chk("rst_busy", 128'(BUSYWAIT), 128'(0));
    chk("rst_mread", 128'(MEM_READ), 128'(0));
    chk("rst_mwrite", 128'(MEM_WRITE), 128'(0));
    chk("rst_rdata", 128'(READDATA), 128'(0));
`ifdef DCACHE_STATS_EN
    chk("rst_hits", 128'(HIT_COUNT), 128'(0));
    chk("rst_miss", 128'(MISS_COUNT), 128'(0));
`endif
    @(posedge CLOCK); #1;
    RESET = 0;

    // Clean miss, store hit, load hit
    access(1, 0, 32'h44, '0, "s1_read");
    access(0, 1, 32'h44, 32'hDEAD_BEEF, "s2_write");
    access(1, 0, 32'h44, '0, "s2_read");
`ifdef DCACHE_STATS_EN
    chk("s6_hits", 128'(HIT_COUNT), 128'(m_hits));
    chk("s6_miss", 128'(MISS_COUNT), 128'(m_misses));
    chk("s6_hits_abs", 128'(HIT_COUNT), 128'(2));
`endif
    // READ and WRITE together is no access
    access(1, 1, 32'h44, 32'h1234_5678, "both_hi");
    access(1, 0, 32'h44, '0, "both_after");
    // Dirty victim written back, then clean victim fetched again
    access(1, 0, 32'hC4, '0, "s3_read");
    access(1, 0, 32'h44, '0, "s4_read");
    access(1, 0, 32'h48, '0, "s4_read_w2");

    // Reset during FETCH aborts the access immediately
    READ = 1; ADDRESS = 32'h144;
    repeat (3) @(negedge CLOCK);
    chk("s5_in_fetch", 128'(MEM_READ), 128'(1));
    #2;
    RESET = 1; READ = 0;
    #1;
    chk("s5_mread_drop", 128'(MEM_READ), 128'(0));
    chk("s5_busy_drop", 128'(BUSYWAIT), 128'(0));
    chk("s5_mwrite", 128'(MEM_WRITE), 128'(0));
    model_reset();
    @(posedge CLOCK); @(posedge CLOCK); #1;
    RESET = 0;
    access(1, 0, 32'h44, '0, "s5_remiss");

    // Randomised traffic over a 1 KiB window (8 tags per index)
    for (int n = 0; n < 120; n++) begin
      bit          rd = 1'($urandom_range(0, 1));
      bit          wr = !rd;
      logic [31:0] a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 15) == 0) begin rd = 1; wr = 1; end
      access(rd, wr, a, $urandom, "rnd");
    end
`ifdef DCACHE_STATS_EN
    chk("end_hits", 128'(HIT_COUNT), 128'(m_hits));
    chk("end_miss", 128'(MISS_COUNT), 128'(m_misses));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
